// File: rtl/rob_pkg.sv
// Shared ROB constants: widths, instruction type codes, the no-dependency tag, entry layout.
package rob_pkg;

  localparam int ROB_SIZE_WIDTH = 3;
  localparam int REG_NUM_WIDTH  = 5;
  localparam int TAG_W          = ROB_SIZE_WIDTH + 1;
  localparam int ROB_ENTRIES    = 1 << ROB_SIZE_WIDTH;

  typedef logic [TAG_W-1:0]          tag_t;
  typedef logic [ROB_SIZE_WIDTH-1:0] idx_t;

  localparam tag_t NO_DEP = '1;

  typedef enum logic [1:0] {
    ROB_TYPE_ALU  = 2'd0,
    ROB_TYPE_BR   = 2'd1,
    ROB_TYPE_ST   = 2'd2,
    ROB_TYPE_JALR = 2'd3
  } rob_type_e;

  typedef struct packed {
    rob_type_e                typ;
    logic [REG_NUM_WIDTH-1:0] rd;
    logic                     pred_taken;
    logic                     mispred;
    logic [31:0]              alt_pc;
    logic [31:0]              value;
  } rob_entry_t;

  // Tags with the top bit set (including NO_DEP) never name a real entry.
  function automatic logic tag_in_range(tag_t t);
    return t[TAG_W-1] == 1'b0;
  endfunction

  function automatic idx_t tag_idx(tag_t t);
    return t[ROB_SIZE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rob_if.sv
// Decoder / CDB / register-file / commit signal bundle around the reorder buffer.
interface rob_if;
  import rob_pkg::*;

  logic                     dec_valid_in;
  logic [1:0]               dec_type_in;
  logic [REG_NUM_WIDTH-1:0] dec_rd_in;
  logic                     dec_pred_taken_in;
  logic [31:0]              dec_alt_pc_in;

  logic                     alu_valid_in;
  tag_t                     alu_tag_in;
  logic [31:0]              alu_value_in;
  logic                     alu_taken_in;

  logic                     lsb_valid_in;
  tag_t                     lsb_tag_in;
  logic [31:0]              lsb_value_in;

  tag_t                     query1_tag_in;
  tag_t                     query2_tag_in;
  logic                     query1_ready_out;
  logic                     query2_ready_out;
  logic [31:0]              query1_value_out;
  logic [31:0]              query2_value_out;

  logic                     full_out;
  tag_t                     new_tag_out;
  logic                     commit_valid_out;
  logic [REG_NUM_WIDTH-1:0] commit_rd_out;
  logic [31:0]              commit_value_out;
  tag_t                     commit_tag_out;
  logic                     store_commit_out;
  logic                     need_flush_out;
  logic [31:0]              flush_pc_out;

  modport master (
    output dec_valid_in, dec_type_in, dec_rd_in, dec_pred_taken_in, dec_alt_pc_in,
    output alu_valid_in, alu_tag_in, alu_value_in, alu_taken_in,
    output lsb_valid_in, lsb_tag_in, lsb_value_in,
    output query1_tag_in, query2_tag_in,
    input  query1_ready_out, query2_ready_out, query1_value_out, query2_value_out,
    input  full_out, new_tag_out,
    input  commit_valid_out, commit_rd_out, commit_value_out, commit_tag_out,
    input  store_commit_out, need_flush_out, flush_pc_out
  );

  modport slave (
    input  dec_valid_in, dec_type_in, dec_rd_in, dec_pred_taken_in, dec_alt_pc_in,
    input  alu_valid_in, alu_tag_in, alu_value_in, alu_taken_in,
    input  lsb_valid_in, lsb_tag_in, lsb_value_in,
    input  query1_tag_in, query2_tag_in,
    output query1_ready_out, query2_ready_out, query1_value_out, query2_value_out,
    output full_out, new_tag_out,
    output commit_valid_out, commit_rd_out, commit_value_out, commit_tag_out,
    output store_commit_out, need_flush_out, flush_pc_out
  );

endinterface

// File: rtl/rob_ptr_ctr.sv
// Circular head/tail pointers and occupancy count for the reorder buffer.
module rob_ptr_ctr
  import rob_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic inc_head,
  input  logic inc_tail,
  input  logic clear,
  output idx_t head,
  output idx_t tail,
  output logic full,
  output logic empty
);

  localparam int unsigned FULL_CNT = ROB_ENTRIES;

  logic [ROB_SIZE_WIDTH:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (inc_head) head <= head + 1'b1;
        if (inc_tail) tail <= tail + 1'b1;
        case ({inc_tail, inc_head})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign full  = (count == FULL_CNT[ROB_SIZE_WIDTH:0]);
  assign empty = (count == '0);

endmodule

// File: rtl/rob.sv
// Reorder buffer: tags issued instructions, captures CDB results, retires in order, flushes on mispredict.
// Optional macro ROB_CDB_FWD_EN lets the query ports see same-cycle CDB results.
module rob
  import rob_pkg::*;
(
  input logic  clk_in,
  input logic  rst_in,
  input logic  rdy_in,
  rob_if.slave bus
);

  logic [ROB_ENTRIES-1:0] busy;
  logic [ROB_ENTRIES-1:0] done;
  rob_entry_t             ent [ROB_ENTRIES];

  idx_t      head;
  idx_t      tail;
  logic      full;
  logic      empty;
  logic      issue;
  logic      commit;
  logic      flush;
  rob_type_e dec_type;
  rob_type_e head_type;
  idx_t      alu_idx;
  idx_t      lsb_idx;
  logic      alu_hit;
  logic      lsb_hit;
  logic [32:0] q1_res;
  logic [32:0] q2_res;

  logic                     commit_vld_p1;
  logic                     store_vld_p1;
  logic                     flush_vld_p1;
  logic [REG_NUM_WIDTH-1:0] commit_rd_p1;
  logic [31:0]              commit_value_p1;
  tag_t                     commit_tag_p1;
  logic [31:0]              flush_pc_p1;

  // p0: issue, writeback and retire decisions on the current entry state
  assign dec_type  = rob_type_e'(bus.dec_type_in);
  assign head_type = ent[head].typ;

  assign alu_idx = tag_idx(bus.alu_tag_in);
  assign lsb_idx = tag_idx(bus.lsb_tag_in);
  assign alu_hit = bus.alu_valid_in && tag_in_range(bus.alu_tag_in) && busy[alu_idx];
  assign lsb_hit = bus.lsb_valid_in && tag_in_range(bus.lsb_tag_in) && busy[lsb_idx];

  assign commit = !empty && busy[head] && done[head];
  assign flush  = commit && (head_type == ROB_TYPE_BR) && ent[head].mispred;
  // A flushing retire wipes the buffer, so anything issued alongside it is dropped.
  assign issue  = bus.dec_valid_in && !full && !flush;

  rob_ptr_ctr u_ptr (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .en       (rdy_in),
    .inc_head (commit && !flush),
    .inc_tail (issue),
    .clear    (flush),
    .head     (head),
    .tail     (tail),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy <= '0;
      done <= '0;
    end else if (rdy_in) begin
      if (alu_hit) done[alu_idx] <= 1'b1;
      if (lsb_hit) done[lsb_idx] <= 1'b1;
      if (commit) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
      end
      if (issue) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
      end
      if (flush) begin
        busy <= '0;
        done <= '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (alu_hit) begin
        ent[alu_idx].value <= bus.alu_value_in;
        if (ent[alu_idx].typ == ROB_TYPE_BR)
          ent[alu_idx].mispred <= (bus.alu_taken_in != ent[alu_idx].pred_taken);
      end
      if (lsb_hit) ent[lsb_idx].value <= bus.lsb_value_in;
      if (issue) begin
        ent[tail].typ        <= dec_type;
        ent[tail].rd         <= bus.dec_rd_in;
        ent[tail].pred_taken <= bus.dec_pred_taken_in;
        ent[tail].mispred    <= 1'b0;
        ent[tail].alt_pc     <= bus.dec_alt_pc_in;
      end
    end
  end

  function automatic logic [32:0] lookup(tag_t t);
    logic [32:0] res;
    idx_t        i;
    res = '0;
    i   = tag_idx(t);
    if (tag_in_range(t) && busy[i]) begin
      if (done[i]) res = {1'b1, ent[i].value};
`ifdef ROB_CDB_FWD_EN
      if (alu_hit && alu_idx == i)      res = {1'b1, bus.alu_value_in};
      else if (lsb_hit && lsb_idx == i) res = {1'b1, bus.lsb_value_in};
`endif
    end
    return res;
  endfunction

  always_comb begin
    q1_res = lookup(bus.query1_tag_in);
    q2_res = lookup(bus.query2_tag_in);
  end

  // p1: registered retire / flush outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_vld_p1   <= 1'b0;
      store_vld_p1    <= 1'b0;
      flush_vld_p1    <= 1'b0;
      commit_rd_p1    <= '0;
      commit_value_p1 <= '0;
      commit_tag_p1   <= '0;
      flush_pc_p1     <= '0;
    end else if (rdy_in) begin
      commit_vld_p1 <= commit;
      store_vld_p1  <= commit && (head_type == ROB_TYPE_ST);
      flush_vld_p1  <= flush;
      if (commit) begin
        commit_rd_p1    <= (head_type == ROB_TYPE_ST || head_type == ROB_TYPE_BR) ? '0 : ent[head].rd;
        commit_value_p1 <= ent[head].value;
        commit_tag_p1   <= {1'b0, head};
      end
      if (flush) flush_pc_p1 <= ent[head].alt_pc;
    end
  end

  assign bus.query1_ready_out = q1_res[32];
  assign bus.query1_value_out = q1_res[31:0];
  assign bus.query2_ready_out = q2_res[32];
  assign bus.query2_value_out = q2_res[31:0];
  assign bus.full_out         = full;
  assign bus.new_tag_out      = {1'b0, tail};
  assign bus.commit_valid_out = commit_vld_p1;
  assign bus.commit_rd_out    = commit_rd_p1;
  assign bus.commit_value_out = commit_value_p1;
  assign bus.commit_tag_out   = commit_tag_p1;
  assign bus.store_commit_out = store_vld_p1;
  assign bus.need_flush_out   = flush_vld_p1;
  assign bus.flush_pc_out     = flush_pc_p1;

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the out-of-order RISC-V core.
- Allocates a tag per decoded instruction and captures ALU/LSB writeback results.
- Retires in program order and drives the register-file commit port (valid/rd/value/dependency) plus the new-dependency tag.
- On branch mispredict at commit, raises the global flush and redirect PC.

Parameters:
- ROB_SIZE_WIDTH, 3, log2 of entry count (8 entries). Tag width is ROB_SIZE_WIDTH+1; all-ones (15) means "no dependency".
- REG_NUM_WIDTH, 5, architectural register index width.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; 0 freezes all state
- dec_valid_in  in  1  decoder issues one instruction
- dec_type_in  in  2  0=ALU/load, 1=branch, 2=store, 3=jalr
- dec_rd_in  in  REG_NUM_WIDTH  destination (0 = none)
- dec_pred_taken_in  in  1  predicted direction (branch)
- dec_alt_pc_in  in  32  PC to redirect to if prediction wrong
- alu_valid_in / alu_tag_in / alu_value_in / alu_taken_in  in  1/TW/32/1  ALU CDB
- lsb_valid_in / lsb_tag_in / lsb_value_in  in  1/TW/32  LSB CDB
- query1_tag_in, query2_tag_in  in  TW  operand tags from RF
- query1_ready_out, query2_ready_out  out  1  entry holds result
- query1_value_out, query2_value_out  out  32  entry result
- full_out  out  1  no free entry
- new_tag_out  out  TW  tag the next issue receives (= tail)
- commit_valid_out  out  1  registered one-cycle retire pulse
- commit_rd_out / commit_value_out / commit_tag_out  out  REG_NUM_WIDTH/32/TW  retire data
- store_commit_out  out  1  pulse: head store may write memory
- need_flush_out  out  1  registered one-cycle flush pulse
- flush_pc_out  out  32  redirect PC, valid with need_flush_out

Behaviour:
- Reset (rst_in=0, async): head=tail=count=0, all entry busy/ready=0. All outputs 0, except new_tag_out=0 and full_out=0.
- rdy_in=0: no state change; registered outputs hold.
- Circular buffer:
  - head/tail are ROB_SIZE_WIDTH bits and wrap 7->0.
  - count is ROB_SIZE_WIDTH+1 bits.
  - full_out = (count == 2^ROB_SIZE_WIDTH), combinational.
- Issue: dec_valid_in && !full_out writes entry[tail] (busy=1, ready=0, fields) and increments tail.
  - Issue while full is ignored; the decoder must not do it.
- Writeback: a CDB valid sets ready=1 and captures value in entry[tag].
  - For a branch, also captures mispredict = (alu_taken_in != pred_taken).
  - ALU and LSB may write different tags in the same cycle.
  - Writeback to a non-busy tag is ignored.
- Commit (one per cycle): if entry[head] busy && ready, then next edge:
  - Pulse commit_valid_out=1 with rd, value and tag=head; rd forced 0 for store/branch.
  - store_commit_out=1 for a store.
  - Clear busy, increment head.
  - A result written back in cycle N commits at the earliest at edge N+1.
- Mispredict: a committing branch with mispredict=1 also pulses need_flush_out=1 with flush_pc_out=alt_pc.
  - At the same edge: head=tail=count=0 and all busy cleared.
  - An issue presented in that cycle is dropped.
- jalr commits rd=link value; it never flushes (the fetch unit resolves it).
- Simultaneous issue and commit: count unchanged, both applied.
- Simultaneous full and commit: issue still refused this cycle (full_out is computed from the current count).
- Query ports:
  - ready = busy && ready bit of entry[tag] (combinational); value = entry value.
  - A no-dependency tag (all-ones) gives ready=0 and value=0.
- Asynchronous reset asserted mid-operation clears everything immediately, including pulses in flight.

Optional Feature:
- ROB_CDB_FWD_EN:
  - Defined: query ports also match same-cycle ALU/LSB CDB tags; a hit returns ready=1 and the CDB value. ALU has priority if both CDBs match.
  - Undefined: query sees only registered entry state, one cycle later.

Decomposition:
- Shared include (const_param): ROB_SIZE_WIDTH, REG_NUM_WIDTH, type codes (ROB_TYPE_ALU/BR/ST/JALR), all-ones no-dependency constant.
- Sub-module rob_ptr_ctr: holds head/tail/count, does wrap-around, and produces full/empty from inc_head, inc_tail and clear.

Test Plan:
- Reset, issue ALU rd=5, ALU writeback tag 0 value 0x1234 -> next cycle commit_valid_out=1, rd=5, value=0x1234, tag=0.
- Issue tags 0,1; writeback 1 then 0 -> commits in order tag 0 then tag 1, one per cycle.
- Issue 8 entries -> full_out=1 and new_tag_out=0 after wrap; a 9th dec_valid is ignored. One commit -> full_out=0 next cycle.
- Branch pred_taken=1, alt_pc=0x100, alu_taken=0, 3 younger entries -> need_flush_out=1, flush_pc_out=0x100, then count=0 and new_tag_out=0.
- Store writeback from LSB -> store_commit_out=1, commit rd=0. Query of a ready tag 2 returns ready=1 and its value. With ROB_CDB_FWD_EN, a same-cycle CDB hit returns ready=1 and the CDB value.
- Assert rst_in=0 mid-stream with 5 busy entries -> all outputs 0 immediately; later issue gets tag 0.
